// File: rtl/latch_wr_arb.sv
// ============================================================================
// latch_wr_arb : arbitrates NREQ writers onto NENT latch entries (setup/open/hold)
// Option macro LATCH_WR_ARB_FIXED_PRIO_EN selects fixed priority.  Rev 1.0
// ============================================================================
`default_nettype none

module latch_wr_arb #(
  parameter int NREQ = 4,
  parameter int NENT = 8,
  parameter int DW   = 32,
  localparam int AW  = (NENT > 1) ? $clog2(NENT) : 1,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NENT-1:0]    lat_en,
  output logic [DW-1:0]      lat_d,
  output logic               busy,
  output logic               addr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [AW:0] NENT_W = (AW+1)'(NENT);

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NENT-1:0] lat_en_q, lat_en_d;
  logic [DW-1:0]   lat_d_q, lat_d_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            busy_q, busy_d;
  logic            addr_err_q, addr_err_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;

  logic [PW-1:0]   win_idx;
  logic [AW-1:0]   win_addr;

  // Descending scan so the candidate closest to the search start wins last.
  always_comb begin
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
`ifdef LATCH_WR_ARB_FIXED_PRIO_EN
      if (req[i]) win_idx = PW'(i);
`else
      if (req[PW'((int'(rr_ptr_q) + i) % NREQ)])
        win_idx = PW'((int'(rr_ptr_q) + i) % NREQ);
`endif
    end
    win_addr = req_addr[win_idx*AW +: AW];
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = '0;
    lat_en_d   = '0;
    addr_err_d = 1'b0;
    lat_d_d    = lat_d_q;
    addr_d     = addr_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d    = SETUP;
          gnt_d      = NREQ'(1) << win_idx;
          addr_d     = win_addr;
          lat_d_d    = req_data[win_idx*DW +: DW];
          addr_err_d = ({1'b0, win_addr} >= NENT_W);
`ifdef LATCH_WR_ARB_FIXED_PRIO_EN
          rr_ptr_d   = '0;
`else
          rr_ptr_d   = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
`endif
        end
      end
      SETUP: state_d = OPEN;
      // The strobe is launched from OPEN so the latch clock comes straight off a flop.
      OPEN: begin
        state_d = HOLD;
        if ({1'b0, addr_q} < NENT_W)
          lat_en_d = NENT'(1) << addr_q;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      lat_en_q   <= '0;
      lat_d_q    <= '0;
      addr_q     <= '0;
      busy_q     <= 1'b0;
      addr_err_q <= 1'b0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      lat_en_q   <= lat_en_d;
      lat_d_q    <= lat_d_d;
      addr_q     <= addr_d;
      busy_q     <= busy_d;
      addr_err_q <= addr_err_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign gnt      = gnt_q;
  assign lat_en   = lat_en_q;
  assign lat_d    = lat_d_q;
  assign busy     = busy_q;
  assign addr_err = addr_err_q;

endmodule

`default_nettype wire
